pulse_encoder: RTL and testbench

PULSE_ENCODER -- requirements
Module: pulse_encoder

---
 rtl/pulse_encoder.sv | 134 +++++++++++++
 tb/tb_pulse_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_encoder.sv
// pulse_encoder: turns a stream of symbols into one-wire high/low pulses,
// with an optional low latch gap between frames.
module pulse_encoder #(
    parameter int unsigned WORD_SZ = 1,
    parameter logic [WORD_SZ-1:0] BIT0 = '0,
    parameter logic [WORD_SZ-1:0] BIT1 = WORD_SZ'(1),
    parameter int unsigned T0H    = 6,
    parameter int unsigned T0L    = 13,
    parameter int unsigned T1H    = 13,
    parameter int unsigned T1L    = 6,
    parameter int unsigned TRESET = 3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_SZ-1:0] sym,
    input  logic               sym_valid,
    input  logic               frame_end,
    output logic               sym_ready,
    output logic               dout,
    output logic               busy,
    output logic               err
);

    localparam int unsigned MAX_0  = (T0H > T0L) ? T0H : T0L;
    localparam int unsigned MAX_1  = (T1H > T1L) ? T1H : T1L;
    localparam int unsigned MAX_01 = (MAX_0 > MAX_1) ? MAX_0 : MAX_1;
    localparam int unsigned MAX_T  = (MAX_01 > TRESET) ? MAX_01 : TRESET;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;     // cycles remaining in current state
    logic [CNT_W-1:0]   low_q, low_d;     // low length of the symbol in flight
    logic               dout_q, dout_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               accept;
    logic               xfer;

    assign xfer = sym_valid && ready_q;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        err_d   = 1'b0;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: accept = 1'b1;
            StHigh: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StLow;
                    cnt_d   = low_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLow: begin
                if (cnt_q == CNT_W'(1)) accept = 1'b1;
                else                    cnt_d  = cnt_q - CNT_W'(1);
            end
            StLatch: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Accepting cycle: a symbol beats frame_end; an unmatched or X symbol
        // falls through both compares and is dropped with an error pulse.
        if (accept) begin
            if (xfer && (sym == BIT1)) begin
                state_d = StHigh;
                cnt_d   = CNT_W'(T1H);
                low_d   = CNT_W'(T1L);
            end else if (xfer && (sym == BIT0)) begin
                state_d = StHigh;
                cnt_d   = CNT_W'(T0H);
                low_d   = CNT_W'(T0L);
            end else begin
                err_d = xfer;
                if (frame_end) begin
                    state_d = StLatch;
                    cnt_d   = CNT_W'(TRESET);
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
        end

        dout_d  = (state_d == StHigh);
        ready_d = (state_d == StIdle) || ((state_d == StLow) && (cnt_d == CNT_W'(1)));
        busy_d  = (state_d != StIdle);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            low_q   <= '0;
            dout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign sym_ready = ready_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pulse_encoder.sv
// Directed bench for pulse_encoder; dut1 is 1-bit symbols, dut2 is 2-bit
// symbols with BIT0=01, BIT1=10. Timings T0H/T0L/T1H/T1L/TRESET = 2/4/4/2/8.
module tb_pulse_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       sym, sym_valid, frame_end;
    logic       sym_ready, dout, busy, err;
    logic [1:0] sym2;
    logic       sym_valid2, frame_end2;
    logic       sym_ready2, dout2, busy2, err2;

    int         nvec = 0;
    int         nerr = 0;
    logic [31:0] dp, rp, bp, ep;

    always #5 clk = ~clk;

    pulse_encoder #(
        .WORD_SZ(1), .BIT0(1'b0), .BIT1(1'b1),
        .T0H(2), .T0L(4), .T1H(4), .T1L(2), .TRESET(8)
    ) dut1 (
        .clk(clk), .reset(reset), .sym(sym), .sym_valid(sym_valid),
        .frame_end(frame_end), .sym_ready(sym_ready), .dout(dout),
        .busy(busy), .err(err)
    );

    pulse_encoder #(
        .WORD_SZ(2), .BIT0(2'b01), .BIT1(2'b10),
        .T0H(2), .T0L(4), .T1H(4), .T1L(2), .TRESET(8)
    ) dut2 (
        .clk(clk), .reset(reset), .sym(sym2), .sym_valid(sym_valid2),
        .frame_end(frame_end2), .sym_ready(sym_ready2), .dout(dout2),
        .busy(busy2), .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge, then compare cycle i of an n-cycle pattern
    task automatic step(input string tag, input int i, input int n, input bit sel);
        tick();
        if (!sel) begin
            chk({tag, ".dout"},  i, dout,      dp[n-i]);
            chk({tag, ".ready"}, i, sym_ready, rp[n-i]);
            chk({tag, ".busy"},  i, busy,      bp[n-i]);
            chk({tag, ".err"},   i, err,       ep[n-i]);
        end else begin
            chk({tag, ".dout"},  i, dout2,      dp[n-i]);
            chk({tag, ".ready"}, i, sym_ready2, rp[n-i]);
            chk({tag, ".busy"},  i, busy2,      bp[n-i]);
            chk({tag, ".err"},   i, err2,       ep[n-i]);
        end
    endtask

    initial begin
        reset = 1'b1; sym = 1'b0; sym_valid = 1'b0; frame_end = 1'b0;
        sym2 = 2'b00; sym_valid2 = 1'b0; frame_end2 = 1'b0;
        dp = '0; rp = '0; bp = '0; ep = '0;

        // Reset state, checked while reset is still asserted
        tick();
        rp = 32'd1; step("reset1", 1, 1, 1'b0);
        step("reset2", 1, 1, 1'b1);

        // Single 1 accepted on the first edge after reset; sym toggled mid-pulse
        reset = 1'b0; sym = 1'b1; sym_valid = 1'b1;
        dp = 32'b1111000; rp = 32'b0000011; bp = 32'b1111110; ep = '0;
        for (int i = 1; i <= 7; i++) begin
            step("single1", i, 7, 1'b0);
            if (i == 1) begin sym_valid = 1'b0; sym = 1'b0; end
        end

        // Back-to-back 0,1,0 with sym_valid held
        sym = 1'b0; sym_valid = 1'b1;
        dp = 32'b110000_111100_110000_0;
        rp = 32'b000001_000001_000001_1;
        bp = 32'b111111_111111_111111_0;
        for (int i = 1; i <= 19; i++) begin
            step("stream", i, 19, 1'b0);
            if (i == 1)  sym = 1'b1;
            if (i == 7)  sym = 1'b0;
            if (i == 13) sym_valid = 1'b0;
        end

        // Frame end raised during a 0 symbol -> 8-cycle latch gap
        sym = 1'b0; sym_valid = 1'b1;
        dp = 32'b110000_00000000_0;
        rp = 32'b000001_00000000_1;
        bp = 32'b111111_11111111_0;
        for (int i = 1; i <= 15; i++) begin
            step("frame", i, 15, 1'b0);
            if (i == 1) begin sym_valid = 1'b0; frame_end = 1'b1; end
            if (i == 7) frame_end = 1'b0;
        end

        // Symbol and frame_end together, frame_end held: pulse then latch
        sym = 1'b1; sym_valid = 1'b1; frame_end = 1'b1;
        dp = 32'b111100_00000000_0;
        rp = 32'b000001_00000000_1;
        bp = 32'b111111_11111111_0;
        for (int i = 1; i <= 15; i++) begin
            step("contend_hold", i, 15, 1'b0);
            if (i == 1) sym_valid = 1'b0;
            if (i == 7) frame_end = 1'b0;
        end

        // Symbol and frame_end together, frame_end dropped: pulse then idle
        sym = 1'b1; sym_valid = 1'b1; frame_end = 1'b1;
        dp = 32'b1111000; rp = 32'b0000011; bp = 32'b1111110;
        for (int i = 1; i <= 7; i++) begin
            step("contend_drop", i, 7, 1'b0);
            if (i == 1) begin sym_valid = 1'b0; frame_end = 1'b0; end
        end

        // frame_end alone in idle -> latch gap
        frame_end = 1'b1;
        dp = 32'b000000000; rp = 32'b000000001; bp = 32'b111111110;
        for (int i = 1; i <= 9; i++) begin
            step("idle_latch", i, 9, 1'b0);
            if (i == 1) frame_end = 1'b0;
        end

        // Reset in cycle 2 of a 1 pulse, then a clean 0 symbol
        sym = 1'b1; sym_valid = 1'b1;
        dp = 32'b1101100000; rp = 32'b0010000011; bp = 32'b1101111110;
        for (int i = 1; i <= 10; i++) begin
            step("midreset", i, 10, 1'b0);
            if (i == 1) sym_valid = 1'b0;
            if (i == 2) reset = 1'b1;
            if (i == 3) begin reset = 1'b0; sym = 1'b0; sym_valid = 1'b1; end
            if (i == 4) sym_valid = 1'b0;
        end

        // Unmatched symbol 11: one-cycle err, stays idle
        sym2 = 2'b11; sym_valid2 = 1'b1;
        dp = 32'b000; rp = 32'b111; bp = 32'b000; ep = 32'b100;
        for (int i = 1; i <= 3; i++) begin
            step("bad_sym", i, 3, 1'b1);
            if (i == 1) sym_valid2 = 1'b0;
        end

        // Unmatched symbol 00 with frame_end: err pulse and latch gap
        sym2 = 2'b00; sym_valid2 = 1'b1; frame_end2 = 1'b1;
        dp = 32'b000000000; rp = 32'b000000001; bp = 32'b111111110; ep = 32'b100000000;
        for (int i = 1; i <= 9; i++) begin
            step("bad_latch", i, 9, 1'b1);
            if (i == 1) begin sym_valid2 = 1'b0; frame_end2 = 1'b0; end
        end

        // Matched 2-bit symbols: 10 is a 1, 01 is a 0
        sym2 = 2'b10; sym_valid2 = 1'b1;
        dp = 32'b1111000; rp = 32'b0000011; bp = 32'b1111110; ep = '0;
        for (int i = 1; i <= 7; i++) begin
            step("wide_one", i, 7, 1'b1);
            if (i == 1) sym_valid2 = 1'b0;
        end
        sym2 = 2'b01; sym_valid2 = 1'b1;
        dp = 32'b1100000; rp = 32'b0000011; bp = 32'b1111110;
        for (int i = 1; i <= 7; i++) begin
            step("wide_zero", i, 7, 1'b1);
            if (i == 1) sym_valid2 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
